// File: rtl/div_pkg.sv
// div_pkg: state encoding and constants shared by the iterative divider.
package div_pkg;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam int DIV_LATENCY = 34;
    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        CALC = S_CALC,
        FIX  = S_FIX,
        DONE = S_DONE
    } state_t;
endpackage

// File: rtl/div_iter_unit_if.sv
// div_iter_unit_if: EXE-stage multi-cycle ALU request/response interface.
interface div_iter_unit_if #(parameter int WIDTH = 32);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [WIDTH-1:0] in_dividend;
    logic [WIDTH-1:0] in_divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quotient;
    logic [WIDTH-1:0] out_remainder;
    logic             busy;
    modport master (
        output flush, in_valid, in_signed, in_dividend, in_divisor, out_ready,
        input  in_ready, out_valid, out_quotient, out_remainder, busy
    );
    modport slave (
        input  flush, in_valid, in_signed, in_dividend, in_divisor, out_ready,
        output in_ready, out_valid, out_quotient, out_remainder, busy
    );
endinterface

// File: rtl/div_iter_step.sv
// div_iter_step: one restoring-division step (shift in a bit, compare, conditional subtract).
module div_iter_step #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] rem,
    input  logic             din,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    assign sh = {rem, din};
    // rem < divisor keeps |sh - divisor| below 2^WIDTH, so bit WIDTH is the borrow
    assign {borrow, diff} = sh - {1'b0, divisor};
    assign q_bit = ~borrow;
    assign rem_next = q_bit ? diff : sh[WIDTH-1:0];
endmodule

// File: rtl/div_iter_unit.sv
// div_iter_unit: iterative radix-2 restoring divider for DIV.W/MOD.W/DIV.WU/MOD.WU.
// Optional DIV_FAST_PATH_EN: finish in one cycle when |dividend| < |divisor|.
module div_iter_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input logic          clk,
    input logic          resetn,
    div_iter_unit_if.slave bus
);
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a, b, r, raw, r_nxt, q_out, r_out, a_mag, b_mag;
    logic             qs, rs, q_bit, accept, fast, sa, sb;

    assign sa = bus.in_signed & bus.in_dividend[WIDTH-1];
    assign sb = bus.in_signed & bus.in_divisor[WIDTH-1];
    assign a_mag = sa ? -bus.in_dividend : bus.in_dividend;
    assign b_mag = sb ? -bus.in_divisor : bus.in_divisor;
    assign accept = bus.in_valid & (state == IDLE) & ~bus.flush;
`ifdef DIV_FAST_PATH_EN
    assign fast = (b_mag != '0) && (a_mag < b_mag);
`else
    assign fast = 1'b0;
`endif

    // a holds the dividend magnitude and fills with quotient bits as it shifts out
    div_iter_step #(.WIDTH(WIDTH)) u_step (
        .rem      (r),
        .din      (a[WIDTH-1]),
        .divisor  (b),
        .rem_next (r_nxt),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? (fast ? DONE : CALC) : IDLE;
            CALC:    state_nxt = (cnt == '0) ? FIX : CALC;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = bus.out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt   <= '0;
            a     <= '0;
            b     <= '0;
            r     <= '0;
            raw   <= '0;
            qs    <= 1'b0;
            rs    <= 1'b0;
            q_out <= '0;
            r_out <= '0;
        end else if (accept) begin
            a   <= a_mag;
            b   <= b_mag;
            r   <= '0;
            cnt <= CNT_W'(WIDTH - 1);
            qs  <= sa ^ sb;
            rs  <= sa;
            raw <= bus.in_dividend;
            if (fast) begin
                q_out <= '0;
                r_out <= bus.in_dividend;
            end
        end else if (state == CALC && !bus.flush) begin
            a <= {a[WIDTH-2:0], q_bit};
            r <= r_nxt;
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end else if (state == FIX && !bus.flush) begin
            q_out <= (b == '0) ? WIDTH'(DIV_BY_ZERO_Q) : (qs ? -a : a);
            r_out <= (b == '0) ? raw : (rs ? -r : r);
        end
    end

    assign bus.in_ready      = (state == IDLE);
    assign bus.out_valid     = (state == DONE);
    assign bus.busy          = (state != IDLE);
    assign bus.out_quotient  = q_out;
    assign bus.out_remainder = r_out;
endmodule

// File: tb/tb_div_iter_unit.sv
// tb_div_iter_unit: directed and random checks of div_iter_unit against an arithmetic reference.
module tb_div_iter_unit;
    import div_pkg::*;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int checks = 0;
    int errors = 0;
    logic cs;
    logic [31:0] ca, cd;

    div_iter_unit_if #(.WIDTH(32)) bus ();
    div_iter_unit #(.WIDTH(32), .CNT_W(5)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic s, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] q, output logic [31:0] r, output int lat);
        logic [31:0] xm, ym;
        xm = (s && x[31]) ? -x : x;
        ym = (s && y[31]) ? -y : y;
        if (y == 0) begin
            q = 32'hFFFF_FFFF;
            r = x;
        end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 0;
        end else if (s) begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
        end else begin
            q = x / y;
            r = x % y;
        end
        lat = DIV_LATENCY;
`ifdef DIV_FAST_PATH_EN
        if (y != 0 && xm < ym) lat = 1;
`endif
    endfunction

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y);
        bus.in_signed = s;
        bus.in_dividend = x;
        bus.in_divisor = y;
        bus.in_valid = 1'b1;
        chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        cs = s; ca = x; cd = y;
    endtask

    task automatic collect(input int bp, input logic chain, input logic s2,
                           input logic [31:0] x2, input logic [31:0] y2);
        logic [31:0] eq, er;
        int lat;
        int n = 1;
        logic bad = 1'b0;
        model(cs, ca, cd, eq, er, lat);
        while (!bus.out_valid && n < 200) begin
            if (bus.in_ready || !bus.busy) bad = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("in_ready_low_calc", {31'd0, bad}, 32'd0);
        chk("latency", n, lat);
        chk("quotient", bus.out_quotient, eq);
        chk("remainder", bus.out_remainder, er);
        repeat (bp) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("hold_q", bus.out_quotient, eq);
            chk("hold_r", bus.out_remainder, er);
            chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        if (chain) begin
            bus.in_signed = s2;
            bus.in_dividend = x2;
            bus.in_divisor = y2;
            bus.in_valid = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("valid_drop", {31'd0, bus.out_valid}, 32'd0);
        chk("in_ready_back", {31'd0, bus.in_ready}, 32'd1);
        if (chain) begin
            @(posedge clk);
            @(negedge clk);
            bus.in_valid = 1'b0;
            chk("b2b_accept", {31'd0, bus.busy}, 32'd1);
            cs = s2; ca = x2; cd = y2;
        end
    endtask

    initial begin
        logic seen;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_signed = 1'b0;
        bus.in_dividend = '0;
        bus.in_divisor = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_q", bus.out_quotient, 32'd0);
        chk("rst_r", bus.out_remainder, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        issue(1'b0, 32'd100, 32'd7);             collect(0, 1'b0, 1'b0, 0, 0);
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);       collect(0, 1'b0, 1'b0, 0, 0);
        issue(1'b1, 32'd7, 32'hFFFF_FFFE);       collect(1, 1'b0, 1'b0, 0, 0);
        issue(1'b0, 32'h1234_5678, 32'd0);       collect(0, 1'b0, 1'b0, 0, 0);
        issue(1'b1, 32'h1234_5678, 32'd0);       collect(0, 1'b0, 1'b0, 0, 0);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        collect(5, 1'b1, 1'b0, 32'd3, 32'd10);
        collect(0, 1'b0, 1'b0, 0, 0);

        // flush mid-CALC
        issue(1'b0, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_idle", {31'd0, bus.in_ready}, 32'd1);
        chk("flush_busy", {31'd0, bus.busy}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            if (bus.out_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("flush_no_valid", {31'd0, seen}, 32'd0);
        issue(1'b0, 32'd50, 32'd5);              collect(0, 1'b0, 1'b0, 0, 0);

        // flush with a request in IDLE is not accepted
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_dividend = 32'd9;
        bus.in_divisor = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_idle_reject", {31'd0, bus.busy}, 32'd0);

        // flush together with out_ready in DONE
        issue(1'b0, 32'd77, 32'd100);
        repeat (60) if (!bus.out_valid) @(negedge clk);
        chk("done_reached", {31'd0, bus.out_valid}, 32'd1);
        bus.flush = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        chk("flush_done_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("flush_done_ready", {31'd0, bus.in_ready}, 32'd1);

        // asynchronous reset mid-CALC
        issue(1'b1, 32'hDEAD_BEEF, 32'd13);
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_q", bus.out_quotient, 32'd0);
        chk("arst_r", bus.out_remainder, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            logic s;
            logic [31:0] x, y;
            int sel;
            s = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 7);
            y = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) :
                (sel == 2) ? 32'hFFFF_FFFF : $urandom;
            x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            if (sel == 3) x = 32'h8000_0000;
            issue(s, x, y);
            collect($urandom_range(0, 2), 1'b0, 1'b0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
